// File: rtl/gtech_reduce_pkg.sv
// rtl/gtech_reduce_pkg.sv - mode encoding, tree sizing and base-op helpers for gtech_reduce_pipe
package gtech_reduce_pkg;

  typedef enum logic [2:0] {
    MODE_OR   = 3'd0,
    MODE_NOR  = 3'd1,
    MODE_AND  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2
  } op_e;

  // Sideband carried alongside the data through every tree level.
  typedef struct packed {
    logic [2:0] mode;
    logic       err;
    logic       last;
  } side_t;

  function automatic int nodes(int width, int fanin, int lvl);
    int n;
    n = width;
    for (int i = 0; i < lvl; i++) n = (n + fanin - 1) / fanin;
    return n;
  endfunction

  function automatic int levels(int width, int fanin);
    int n;
    int l;
    n = width;
    l = 0;
    for (int i = 0; i < 16; i++) begin
      if (n > 1) begin
        n = (n + fanin - 1) / fanin;
        l++;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  function automatic op_e base_op(logic [2:0] mode);
    case (mode)
      MODE_AND, MODE_NAND: return OP_AND;
      MODE_XOR, MODE_XNOR: return OP_XOR;
      default:             return OP_OR;
    endcase
  endfunction

  function automatic logic identity(op_e op);
    return (op == OP_AND);
  endfunction

  function automatic logic is_inverting(logic [2:0] mode);
    return (mode == MODE_NOR) || (mode == MODE_NAND) || (mode == MODE_XNOR);
  endfunction

  function automatic logic is_reserved(logic [2:0] mode);
    return (mode > MODE_XNOR);
  endfunction

  function automatic logic combine(op_e op, logic a, logic b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

endpackage

// File: rtl/gtech_reduce_level.sv
// rtl/gtech_reduce_level.sv - one registered FANIN-ary tree level with valid/sideband, advanced by adv_i
module gtech_reduce_level
  import gtech_reduce_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FANIN = 4,
  parameter int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [IN_W-1:0]  data_i,
  input  side_t            side_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output side_t            side_o
);

  op_e                     op;
  logic [OUT_W*FANIN-1:0]  pad;
  logic [OUT_W-1:0]        data_d;
  logic                    node_v;

  logic                    valid_q;
  logic [OUT_W-1:0]        data_q;
  side_t                   side_q;

  // Leaves beyond IN_W take the identity of the op so they never change a node result.
  always_comb begin
    op             = base_op(side_i.mode);
    pad            = {(OUT_W*FANIN){identity(op)}};
    pad[IN_W-1:0]  = data_i;
    data_d         = '0;
    node_v         = 1'b0;
    for (int j = 0; j < OUT_W; j++) begin
      node_v = pad[j*FANIN];
      for (int i = 1; i < FANIN; i++) node_v = combine(op, node_v, pad[j*FANIN+i]);
      data_d[j] = node_v;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      side_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      side_q  <= side_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign side_o  = side_q;

endmodule

// File: rtl/gtech_reduce_pipe.sv
// rtl/gtech_reduce_pipe.sv - pipelined WIDTH-bit reduction gate, one register per tree level
// Optional group accumulation with IN_LAST when GTECH_REDUCE_ACCUM_EN is defined.
module gtech_reduce_pipe
  import gtech_reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [2:0]       IN_MODE,
`ifdef GTECH_REDUCE_ACCUM_EN
  input  logic             IN_LAST,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_Z,
  output logic             OUT_ERR
);

  localparam int LEVELS = levels(WIDTH, FANIN);

  logic  adv;
  side_t side_in;
  logic  fin_v;
  logic  fin_z;
  side_t fin_s;
  logic  fold_z;
  logic  fold_err;

  assign adv      = ~OUT_VALID | OUT_READY;
  assign IN_READY = adv;

  assign side_in.mode = IN_MODE;
  assign side_in.err  = is_reserved(IN_MODE);
`ifdef GTECH_REDUCE_ACCUM_EN
  assign side_in.last = IN_LAST;
`else
  assign side_in.last = 1'b1;
`endif

  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    localparam int IN_W  = nodes(WIDTH, FANIN, g);
    localparam int OUT_W = nodes(WIDTH, FANIN, g + 1);

    logic             v_in;
    logic [IN_W-1:0]  d_in;
    side_t            s_in;
    logic             v_out;
    logic [OUT_W-1:0] d_out;
    side_t            s_out;

    if (g == 0) begin : g_src
      assign v_in = IN_VALID;
      assign d_in = IN_DATA;
      assign s_in = side_in;
    end else begin : g_chain
      assign v_in = g_lvl[g-1].v_out;
      assign d_in = g_lvl[g-1].d_out;
      assign s_in = g_lvl[g-1].s_out;
    end

    gtech_reduce_level #(
      .IN_W  (IN_W),
      .FANIN (FANIN),
      .OUT_W (OUT_W)
    ) u_level (
      .clk_i   (CLK),
      .rst_i   (RST),
      .adv_i   (adv),
      .valid_i (v_in),
      .data_i  (d_in),
      .side_i  (s_in),
      .valid_o (v_out),
      .data_o  (d_out),
      .side_o  (s_out)
    );
  end

  assign fin_v = g_lvl[LEVELS-1].v_out;
  assign fin_z = g_lvl[LEVELS-1].d_out[0];
  assign fin_s = g_lvl[LEVELS-1].s_out;

`ifdef GTECH_REDUCE_ACCUM_EN
  logic acc_seen_q;
  logic acc_z_q;
  logic acc_err_q;

  // acc_seen_q stands in for the identity, so the group's op need not be known up front.
  assign fold_z   = acc_seen_q ? combine(base_op(fin_s.mode), acc_z_q, fin_z) : fin_z;
  assign fold_err = acc_err_q | fin_s.err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_seen_q <= 1'b0;
      acc_z_q    <= 1'b0;
      acc_err_q  <= 1'b0;
    end else if (fin_v && adv) begin
      if (fin_s.last) begin
        acc_seen_q <= 1'b0;
        acc_z_q    <= 1'b0;
        acc_err_q  <= 1'b0;
      end else begin
        acc_seen_q <= 1'b1;
        acc_z_q    <= fold_z;
        acc_err_q  <= fold_err;
      end
    end
  end
`else
  assign fold_z   = fin_z;
  assign fold_err = fin_s.err;
`endif

  assign OUT_VALID = fin_v & fin_s.last;
  assign OUT_ERR   = fold_err;
  assign OUT_Z     = fold_err ? 1'b0 : (fold_z ^ is_inverting(fin_s.mode));

endmodule

// File: doc/gtech_reduce_pipe.md
# gtech_reduce_pipe

Parametrised, pipelined N-input reduction gate that generalises the fixed 4-input GTECH gates (NOR4, AND4, XOR4, …) to arbitrary width and a per-beat selectable function. It reduces a WIDTH-bit vector through a FANIN-ary tree with one register per tree level, under a valid/ready handshake. It sits in the GTECH technology-independent library as the standard wide-gate primitive for synthesis mapping and simulation.

## Interface
- WIDTH, 16: number of input bits reduced; 1..256.
- FANIN, 4: inputs per tree node; 2..8.
- LEVELS, derived: ceil(log_FANIN(WIDTH)), minimum 1; not overridable.
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  reset, synchronous and active-high.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  block accepts the beat this cycle.
- IN_DATA  input  WIDTH  operand vector.
- IN_MODE  input  3  function: 0 OR, 1 NOR, 2 AND, 3 NAND, 4 XOR, 5 XNOR; 6–7 reserved.
- IN_LAST  input  1  end of accumulation group; present only with GTECH_REDUCE_ACCUM_EN.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- OUT_Z  output  1  reduction result.
- OUT_ERR  output  1  beat carried a reserved mode.

## Operation
- Base op per mode: OR/NOR use OR tree, AND/NAND use AND tree, XOR/XNOR use XOR tree. Inversion (NOR, NAND, XNOR) is applied once, after the final level.
- Tree padding: unused leaf inputs are tied to the identity of the base op (0 for OR/XOR, 1 for AND).
- Mode and error flag travel with the data through every stage, so consecutive beats may use different modes.
- Reserved mode: OUT_Z = 0 and OUT_ERR = 1 for that beat only. The beat occupies a normal slot.
- WIDTH = 1: one register stage. OUT_Z = IN_DATA, or ~IN_DATA for inverting modes.

## Timing
- Reset: all stage valids cleared. OUT_VALID = 0, OUT_Z = 0, OUT_ERR = 0, accumulator cleared. IN_READY = 1 in the first cycle after RST deasserts.
- Advance enable: adv = ~OUT_VALID | OUT_READY. All stages shift together when adv = 1 (global stall, no bubbles collapsed).
- IN_READY = adv, combinational from OUT_READY and OUT_VALID.
- A beat is accepted on the edge where IN_VALID & IN_READY.
- Latency: the result appears LEVELS cycles after acceptance, when there is no stall. Throughput is 1 beat/cycle.
- Stall: while OUT_VALID & ~OUT_READY, OUT_Z, OUT_ERR and all stage contents hold.
- Beats are never dropped or duplicated.
- Reset mid-operation: all in-flight beats are discarded in the same cycle. No partial result is emitted.

## Configuration
- Macro GTECH_REDUCE_ACCUM_EN.
- **Defined:**
  - IN_LAST port exists.
  - Final-stage results are folded with the base op into an accumulator; an accumulator with reserved mode set ORs into the error flag.
  - OUT_VALID pulses only for the beat with IN_LAST = 1. That beat delivers accum op current, with inversion applied, and the accumulator returns to identity.
  - Mode is sampled from the IN_LAST beat. Mixed modes within a group are undefined.
  - Output latency is unchanged.
- **Undefined:** no IN_LAST port; every beat produces one result.

## Structure
- Package gtech_reduce_pkg holds:
  - the mode enum (MODE_OR…MODE_XNOR);
  - a levels(width, fanin) constant function;
  - base-op and identity helper functions.
- Sub-module gtech_reduce_level: one registered tree level (FANIN-ary node array, valid/mode/err sideband, adv enable). It is instantiated LEVELS times via generate.

## Test plan
- **Single NOR beat:** WIDTH=16, FANIN=4, mode 1, data 0x0000 → OUT_Z=1 two cycles after acceptance. Data 0x0100 → OUT_Z=0.
- **Mixed-mode stream:** back-to-back beats, OUT_READY=1:
  - XOR 0x0007 → 1
  - AND 0xFFFF → 1
  - NAND 0xFFFF → 0
  - Results arrive in consecutive cycles, in order.
- **Backpressure:** hold OUT_READY=0 for 3 cycles with a result pending → OUT_Z stable and IN_READY=0. On release, all beats emerge in order with none lost.
- **Padding:** WIDTH=5, FANIN=4, AND 0x1F → 1. XOR 0x10 → 1 (padding not corrupting the result).
- **Reserved mode:** mode 6 → OUT_Z=0, OUT_ERR=1. The next OR 0x0001 beat → OUT_Z=1, OUT_ERR=0.
- **Reset and accumulate:**
  - Assert RST with 2 beats in flight → no OUT_VALID afterwards.
  - With GTECH_REDUCE_ACCUM_EN: OR beats 0x0000, 0x0000, then 0x0040 with LAST → single OUT_VALID with OUT_Z=1.
